// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, press/release debounce
// and hex decode into a two-deep digit history for the dual seven-segment driver.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 12000,
  parameter int unsigned DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_REL
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    meta_q, rs_q;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [3:0]    new_q, new_d;
  logic [3:0]    old_q, old_d;
  logic          kv_q, kv_d;
  logic [1:0]    low_row;
  logic          row_low;

  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] v;
    case ({r, c})
      4'b00_00: v = 4'h1;
      4'b00_01: v = 4'h2;
      4'b00_10: v = 4'h3;
      4'b00_11: v = 4'hA;
      4'b01_00: v = 4'h4;
      4'b01_01: v = 4'h5;
      4'b01_10: v = 4'h6;
      4'b01_11: v = 4'hB;
      4'b10_00: v = 4'h7;
      4'b10_01: v = 4'h8;
      4'b10_10: v = 4'h9;
      4'b10_11: v = 4'hC;
      4'b11_00: v = 4'hE;
      4'b11_01: v = 4'h0;
      4'b11_10: v = 4'hF;
      default:  v = 4'hD;
    endcase
    return v;
  endfunction

  // Scan from row 3 down so the last hit, the lowest-index low row, wins.
  always_comb begin
    low_row = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rs_q[3-i]) low_row = 2'(3 - i);
    end
  end

  assign row_low = ~rs_q[row_q];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    stab_d  = stab_q;
    new_d   = new_q;
    old_d   = old_q;
    kv_d    = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (rs_q == 4'b1111) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d   = low_row;
            stab_d  = '0;
            state_d = DEB_PRESS;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (!row_low) begin
          dwell_d = '0;
          state_d = SCAN;
        end else if (stab_q == STABLE_LAST) begin
          old_d   = new_q;
          new_d   = decode(row_q, col_q);
          kv_d    = 1'b1;
          state_d = HELD;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      HELD: begin
        if (!row_low) begin
          stab_d  = '0;
          state_d = DEB_REL;
        end
      end
      default: begin
        if (row_low) begin
          state_d = HELD;
        end else if (stab_q == STABLE_LAST) begin
          col_d   = col_q + 2'd1;
          dwell_d = '0;
          state_d = SCAN;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= '1;
      rs_q    <= '1;
      state_q <= SCAN;
      col_q   <= '0;
      row_q   <= '0;
      dwell_q <= '0;
      stab_q  <= '0;
      new_q   <= '0;
      old_q   <= '0;
      kv_q    <= 1'b0;
    end else begin
      meta_q  <= rows;
      rs_q    <= meta_q;
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      stab_q  <= stab_d;
      new_q   <= new_d;
      old_q   <= old_d;
      kv_q    <= kv_d;
    end
  end

  assign cols      = ~(4'b0001 << col_q);
  assign digit_new = new_q;
  assign digit_old = old_q;
  assign key_valid = kv_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model driven by a press mask,
// a table of press/hold/release records, and hand sequences for bounce and reset.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] digit_new, digit_old;
  logic       key_valid;
  logic [15:0] mask;

  int tests = 0;
  int fails = 0;
  int total_pulses = 0;
  int bad_changes = 0;
  logic [3:0] pn = '0, po = '0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .digit_new(digit_new), .digit_old(digit_old), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Pressed key at (r,c) pulls row r low only while column c is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) total_pulses = total_pulses + 1;
    if (!reset && key_valid !== 1'b1 && (digit_new !== pn || digit_old !== po))
      bad_changes = bad_changes + 1;
    pn = digit_new;
    po = digit_old;
  end

  typedef struct {
    logic [15:0] mask;
    int          hold;
    logic [3:0]  exp_new;
    logic [3:0]  exp_old;
    logic [3:0]  held;
    logic [3:0]  after;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_kv(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cols_eq(input logic [3:0] v, input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cols === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cols_ne(input logic [3:0] v, input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cols !== v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic       ok;
    logic       frozen;
    logic [3:0] one;
    logic [3:0] exp_cols;
    int         base;

    tbl[0] = '{16'h0020, 50, 4'h5, 4'h0, 4'b1101, 4'b1011};
    tbl[1] = '{16'h0008,  6, 4'hA, 4'h5, 4'b0111, 4'b1110};
    tbl[2] = '{16'h0001,  6, 4'h1, 4'hA, 4'b1110, 4'b1101};
    tbl[3] = '{16'h1000,  6, 4'hE, 4'h1, 4'b1110, 4'b1101};
    tbl[4] = '{16'h8000,  6, 4'hD, 4'hE, 4'b0111, 4'b1110};
    tbl[5] = '{16'h0800,  6, 4'hC, 4'hD, 4'b0111, 4'b1110};
    tbl[6] = '{16'h0400,  6, 4'h9, 4'hC, 4'b1011, 4'b0111};
    tbl[7] = '{16'h0101,  6, 4'h1, 4'h9, 4'b1110, 4'b1101};
    tbl[8] = '{16'h0040,  6, 4'h6, 4'h1, 4'b1011, 4'b0111};
    tbl[9] = '{16'h4000,  6, 4'hF, 4'h6, 4'b1011, 4'b0111};

    mask  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-scan, checked before any clock edge.
    reset = 1'b1;
    #1;
    chk("reset_cols", cols, 4'b1110);
    chk("reset_new", digit_new, 4'h0);
    chk("reset_old", digit_old, 4'h0);
    chk("reset_kv", key_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    one = 4'b0001;
    for (int n = 1; n <= 17; n++) begin
      @(posedge clk);
      #1;
      exp_cols = ~(one << ((n / 4) % 4));
      chk("scan_seq", cols, exp_cols);
    end

    foreach (tbl[k]) begin
      base = total_pulses;
      mask = tbl[k].mask;
      wait_kv(80, ok);
      chk("kv_seen", ok, 1'b1);
      chk("digit_new", digit_new, tbl[k].exp_new);
      chk("digit_old", digit_old, tbl[k].exp_old);
      frozen = (cols === tbl[k].held);
      repeat (tbl[k].hold) begin
        @(negedge clk);
        if (cols !== tbl[k].held) frozen = 1'b0;
      end
      chk("cols_frozen", frozen, 1'b1);
      chk("one_pulse", total_pulses - base, 1);
      mask = '0;
      wait_cols_ne(tbl[k].held, 40, ok);
      chk("resume_timeout", ok, 1'b1);
      chk("resume_cols", cols, tbl[k].after);
    end

    // Press bounce on key 5: never stable for the full debounce window.
    base = total_pulses;
    mask = 16'h0020;
    wait_cols_eq(4'b1101, 40, ok);
    chk("bp_col_timeout", ok, 1'b1);
    repeat (5) @(negedge clk);
    mask = '0;
    @(negedge clk);
    mask = 16'h0020;
    repeat (3) @(negedge clk);
    mask = '0;
    wait_cols_ne(4'b1101, 40, ok);
    chk("bp_resume_timeout", ok, 1'b1);
    chk("bp_resume_cols", cols, 4'b1011);
    chk("bp_no_pulse", total_pulses - base, 0);
    chk("bp_new", digit_new, 4'hF);
    chk("bp_old", digit_old, 4'h6);

    // Release bounce on key 0 (r3/c1).
    base = total_pulses;
    mask = 16'h2000;
    wait_kv(80, ok);
    chk("br_kv_seen", ok, 1'b1);
    chk("br_new", digit_new, 4'h0);
    chk("br_old", digit_old, 4'hF);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      mask = (i % 2 == 0) ? 16'h0000 : 16'h2000;
      @(negedge clk);
    end
    mask = 16'h2000;
    repeat (4) @(negedge clk);
    chk("br_still_held", cols, 4'b1101);
    mask = '0;
    wait_cols_ne(4'b1101, 40, ok);
    chk("br_resume_timeout", ok, 1'b1);
    chk("br_resume_cols", cols, 4'b1011);
    chk("br_one_pulse", total_pulses - base, 1);
    chk("br_new_after", digit_new, 4'h0);

    // Reset while debouncing a press of key 5.
    base = total_pulses;
    mask = 16'h0020;
    wait_cols_eq(4'b1101, 40, ok);
    chk("rd_col_timeout", ok, 1'b1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rd_cols", cols, 4'b1110);
    chk("rd_new", digit_new, 4'h0);
    chk("rd_old", digit_old, 4'h0);
    chk("rd_kv", key_valid, 1'b0);
    chk("rd_no_pulse", total_pulses - base, 0);
    mask = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rd_after_new", digit_new, 4'h0);
    chk("rd_after_pulses", total_pulses - base, 0);

    chk("digits_only_on_kv", bad_changes, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
